// File: rtl/dsp_mac_pkg.sv
// ============================================================================
// Module : dsp_mac_pkg
// Brief  : Shared widths, drain FSM state type and requantisation helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dsp_mac_pkg;

    localparam int ACC_W = 27;
    localparam int OUT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } drain_state_t;

    // Round-half-up, arithmetic shift right, then clamp to the signed OUT_W range.
    function automatic logic [OUT_W-1:0] sat_round(
        input logic signed [ACC_W-1:0] acc,
        input logic        [4:0]       shift
    );
        logic signed [ACC_W:0] w_rnd;
        logic signed [ACC_W:0] w_sum;
        logic signed [ACC_W:0] w_r;
        logic signed [ACC_W:0] w_max;
        logic signed [ACC_W:0] w_min;
        logic        [OUT_W-1:0] w_res;
        w_max = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
        w_min = ~w_max;
        w_rnd = '0;
        if (shift != 5'd0) begin
            w_rnd[shift - 5'd1] = 1'b1;
        end
        w_sum = {acc[ACC_W-1], acc} + w_rnd;
        w_r   = w_sum >>> shift;
        if (w_r > w_max) begin
            w_res = w_max[OUT_W-1:0];
        end else if (w_r < w_min) begin
            w_res = w_min[OUT_W-1:0];
        end else begin
            w_res = w_r[OUT_W-1:0];
        end
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_result_fifo.sv
// ============================================================================
// Module : dsp_result_fifo
// Brief  : DEPTH x W synchronous FIFO, async reset, occupancy count output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dsp_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop = i_pop & (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // Upstream credit accounting must keep the FIFO from ever being pushed while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && (r_count == CW'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/dsp_mac_drain.sv
// ============================================================================
// Module : dsp_mac_drain
// Brief  : Windowed DSP MAC control with latency-matched capture, requantise
//          and credit-protected result FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dsp_mac_drain #(
    parameter int ACC_W    = dsp_mac_pkg::ACC_W,
    parameter int OUT_W    = dsp_mac_pkg::OUT_W,
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 3,
    parameter int DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [4:0]       cfg_shift,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             op_en,
    output logic             accumulate,
    input  logic [ACC_W-1:0] resulta,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    import dsp_mac_pkg::*;

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   c_depth = CW'(DEPTH);

    drain_state_t            r_state;
    drain_state_t            w_state_nxt;
    logic [LEN_W-1:0]        r_beat_cnt;
    logic [LEN_W-1:0]        r_len;
    logic [4:0]              r_shift;
    logic [CW-1:0]           r_credit;
    logic [PIPE_LAT-1:0]     r_tag;
    logic [4:0]              r_tag_shift [PIPE_LAT];
    logic signed [ACC_W-1:0] r_cap;
    logic [4:0]              r_cap_shift;
    logic                    r_cap_vld;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_pop;
    logic                    w_start;
    logic [CW-1:0]           w_fifo_count;
    logic [OUT_W-1:0]        w_push_data;

    assign w_accept = in_valid & in_ready;
    assign w_last   = w_accept & (r_beat_cnt == (r_len - LEN_W'(1)));
    assign w_pop    = out_valid & out_ready;

    // A back-to-back window may claim the slot freed by a pop on the same edge.
    assign w_start  = (r_state == IDLE)
                    ? (enable & (r_credit < c_depth))
                    : (w_last & enable & ((r_credit - CW'(w_pop)) < c_depth));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)            w_state_nxt = RUN;
            RUN:     if (w_last && !w_start) w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    // accumulate is not gated by the beat: a stalled slot must add zero, not clear.
    always_comb begin
        in_ready   = (r_state == RUN);
        op_en      = in_valid & (r_state == RUN);
        accumulate = (r_state == RUN) & (r_beat_cnt != '0);
        busy       = (r_state != IDLE) | (r_credit != '0) | (w_fifo_count != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= '0;
            r_len      <= LEN_W'(1);
            r_shift    <= '0;
            r_credit   <= '0;
            r_tag      <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_tag_shift[i] <= '0;
            end
            r_cap       <= '0;
            r_cap_shift <= '0;
            r_cap_vld   <= 1'b0;
        end else begin
            if (w_start) begin
                r_beat_cnt <= '0;
                r_len      <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                r_shift    <= cfg_shift;
            end else if (w_accept) begin
                r_beat_cnt <= w_last ? '0 : (r_beat_cnt + LEN_W'(1));
            end

            r_credit <= r_credit + CW'(w_start) - CW'(w_pop);

            // Each tag carries its window's shift so a new window may reconfigure early.
            r_tag[0]       <= w_last;
            r_tag_shift[0] <= r_shift;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag[i]       <= r_tag[i-1];
                r_tag_shift[i] <= r_tag_shift[i-1];
            end

            r_cap_vld <= r_tag[PIPE_LAT-1];
            if (r_tag[PIPE_LAT-1]) begin
                r_cap       <= resulta;
                r_cap_shift <= r_tag_shift[PIPE_LAT-1];
            end
        end
    end

    assign w_push_data = sat_round(r_cap, r_cap_shift);

    dsp_result_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_cap_vld),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_count (w_fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_dsp_mac_drain.sv
// ============================================================================
// Module : tb_dsp_mac_drain
// Brief  : Directed and random bench for dsp_mac_drain with a DSP model and
//          window-level result scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dsp_mac_drain;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              enable    = 1'b0;
    logic [9:0]        cfg_len   = 10'd1;
    logic [4:0]        cfg_shift = 5'd0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic              op_en;
    logic              accumulate;
    logic [26:0]       resulta;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic signed [7:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;

    always #5 clk = ~clk;

    dsp_mac_drain dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_len    (cfg_len),
        .cfg_shift  (cfg_shift),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_en      (op_en),
        .accumulate (accumulate),
        .resulta    (resulta),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    // Dual 8x8 DSP: operand regs, product reg, accumulator (3 edges of latency).
    int   d_p0 = 0, d_p1 = 0, d_acc = 0;
    logic d_a0 = 1'b0, d_a1 = 1'b0;
    always @(posedge clk) begin
        d_p0  <= op_en ? (int'(a1) * int'(b1) + int'(a2) * int'(b2)) : 0;
        d_a0  <= accumulate;
        d_p1  <= d_p0;
        d_a1  <= d_a0;
        d_acc <= d_a1 ? (d_acc + d_p1) : d_p1;
    end
    assign resulta = d_acc[26:0];

    int          total = 0;
    int          bad   = 0;
    longint      exp_q[$];
    longint      m_sum = 0;
    int          m_idx = 0;
    int          m_len = 1;
    int          m_shift = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          ov_rise_cyc = -100;
    logic        ov_prev = 1'b0;
    int          n_acc = 0;
    int          n_acc0 = 0;
    int          n_pop = 0;
    logic [3:0]  acc_pat = '0;
    longint      last_pop = 0;
    logic        acc_now = 1'b0;
    logic        obs_in_ready, obs_busy, obs_out_valid, obs_op_en, obs_accum;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint requant(input longint s, input int sh);
        longint d, num, q;
        d   = longint'(1) << sh;
        num = s + ((sh > 0) ? (d / 2) : 0);
        q   = num / d;
        if ((num % d != 0) && (num < 0)) q = q - 1;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic set_cfg(input int len, input int sh);
        cfg_len   = 10'(len);
        cfg_shift = 5'(sh);
        m_len     = (len == 0) ? 1 : len;
        m_shift   = sh;
    endtask

    // Observe 1ns after the falling edge, then advance to the next falling edge.
    task automatic step();
        #1;
        obs_in_ready  = in_ready;
        obs_busy      = busy;
        obs_out_valid = out_valid;
        obs_op_en     = op_en;
        obs_accum     = accumulate;
        acc_now       = 1'b0;
        if (in_valid && in_ready) begin
            acc_now      = 1'b1;
            n_acc++;
            last_acc_cyc = cyc;
            chk("accumulate", accumulate, (m_idx != 0));
            chk("op_en_beat", op_en, 1);
            acc_pat = {acc_pat[2:0], accumulate};
            if (!accumulate) n_acc0++;
            m_sum += longint'(a1) * longint'(b1) + longint'(a2) * longint'(b2);
            m_idx++;
            if (m_idx == m_len) begin
                exp_q.push_back(requant(m_sum, m_shift));
                m_idx = 0;
                m_sum = 0;
            end
        end
        if (out_valid && !ov_prev) ov_rise_cyc = cyc;
        ov_prev = out_valid;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", out_valid, 0);
            else                   chk("result", $signed(out_data), exp_q.pop_front());
            last_pop = longint'($signed(out_data));
            n_pop++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_beat(input int x1, input int y1, input int x2, input int y2);
        a1 = 8'(x1); b1 = 8'(y1); a2 = 8'(x2); b2 = 8'(y2);
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc_now) break;
        end
        chk("beat_accept", acc_now, 1);
        in_valid = 1'b0;
    endtask

    task automatic start_window();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_in_ready",   in_ready,   0);
        chk("rst_op_en",      op_en,      0);
        chk("rst_accumulate", accumulate, 0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_data",   out_data,   0);
        chk("rst_busy",       busy,       0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;

        // 1: basic window, accumulate pattern and latency
        set_cfg(4, 0);
        start_window();
        ov_rise_cyc = -100;
        for (int i = 0; i < 4; i++) send_beat(2, 2, 3, 3);
        chk("t1_acc_pattern", acc_pat, 4'b0111);
        wait_drain();
        chk("t1_result", last_pop, 52);
        chk("t1_latency", ov_rise_cyc - last_acc_cyc, 5);

        // 2: rounding shift and positive saturation
        set_cfg(4, 2);
        start_window();
        for (int i = 0; i < 4; i++) send_beat(2, 2, 3, 3);
        wait_drain();
        chk("t2_shift2", last_pop, 13);
        set_cfg(4, 0);
        start_window();
        for (int i = 0; i < 4; i++) send_beat(127, 127, 127, 127);
        wait_drain();
        chk("t2_sat_pos", last_pop, 127);

        // 3: negative rounding, negative saturation, cfg_len 0 means 1
        set_cfg(1, 8);
        start_window();
        send_beat(-128, 127, 0, 0);
        wait_drain();
        chk("t3_neg_round", last_pop, -63);
        set_cfg(1, 4);
        start_window();
        send_beat(-128, 127, 0, 0);
        wait_drain();
        chk("t3_sat_neg", last_pop, -128);
        set_cfg(0, 0);
        start_window();
        send_beat(5, -7, 2, 3);
        wait_drain();
        chk("t3_len0", last_pop, -29);

        // 4: input stall mid-window
        set_cfg(4, 0);
        n_acc0 = 0;
        start_window();
        send_beat(2, 2, 3, 3);
        send_beat(2, 2, 3, 3);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_gap_op_en", obs_op_en, 0);
            chk("t4_gap_acc", obs_accum, 1);
        end
        send_beat(2, 2, 3, 3);
        send_beat(2, 2, 3, 3);
        wait_drain();
        chk("t4_result", last_pop, 52);
        chk("t4_acc_zero_once", n_acc0, 1);

        // 5: backpressure limits windows to FIFO depth
        set_cfg(1, 6);
        out_ready = 1'b0;
        n_acc = 0;
        enable = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
            step();
        end
        chk("t5_windows_full", n_acc, 2);
        chk("t5_in_ready_low", obs_in_ready, 0);
        chk("t5_busy", obs_busy, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
            step();
        end
        chk("t5_one_more", n_acc, 3);
        enable = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        step();
        chk("t5_idle_busy", obs_busy, 0);

        // 6: asynchronous reset mid-window discards everything
        out_ready = 1'b0;
        set_cfg(4, 0);
        start_window();
        for (int i = 0; i < 4; i++) send_beat(2, 2, 3, 3);
        for (int i = 0; i < 8; i++) step();
        chk("t6_held_result", obs_out_valid, 1);
        start_window();
        send_beat(9, 9, 9, 9);
        send_beat(9, 9, 9, 9);
        in_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("t6_in_ready",   in_ready,   0);
        chk("t6_op_en",      op_en,      0);
        chk("t6_accumulate", accumulate, 0);
        chk("t6_out_valid",  out_valid,  0);
        chk("t6_out_data",   out_data,   0);
        chk("t6_busy",       busy,       0);
        exp_q.delete();
        m_idx = 0;
        m_sum = 0;
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        start_window();
        for (int i = 0; i < 4; i++) send_beat(2, 2, 3, 3);
        wait_drain();
        chk("t6_fresh", last_pop, 52);

        // 7: random traffic against the window scoreboard
        set_cfg(int'($urandom_range(1, 6)), int'($urandom_range(0, 12)));
        enable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
            step();
        end
        enable = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
            step();
            if (!obs_in_ready) break;
        end
        in_valid = 1'b0;
        chk("t7_windows_closed", m_idx, 0);
        wait_drain();
        step();
        chk("t7_idle_busy", obs_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
